// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// data width and a helper that sizes saturating counters.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    GAP
  } tx_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first set request strictly after
// the pointer, wrapping, wins. Usable by any shared resource arbiter.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = '0;
    for (int i = 1; i <= N; i++) begin
      pos = IDX_W'((int'(ptr) + i) % N);
      if (!valid && req[pos]) begin
        valid       = 1'b1;
        idx         = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte
// producers, with an enforced inter-frame gap and a completion watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 200000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             grant,
  output logic [N_REQ-1:0]             ack,
  output logic                         uart_send,
  output logic [UART_DATA_W-1:0]       uart_tx_data,
  input  logic                         uart_tx_done,
  output logic                         busy,
  output logic                         timeout_err,
  output logic [2:0]                   err_id
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = cnt_width(TIMEOUT);
  localparam int GAP_W = cnt_width(GAP_CYCLES);

  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_REQ - 1);

  tx_state_e              state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic                   send_q, send_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   terr_q, terr_d;
  logic [2:0]             err_id_q, err_id_d;

  logic [N_REQ-1:0]       win_onehot;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_valid;
  logic [UART_DATA_W-1:0] req_bytes [N_REQ];

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (win_onehot),
    .idx    (win_idx),
    .valid  (win_valid)
  );

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_bytes[k] = req_data[k*UART_DATA_W +: UART_DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wd_d     = wd_q;
    gap_d    = gap_q;
    grant_d  = grant_q;
    ack_d    = '0;
    send_d   = 1'b0;
    data_d   = data_q;
    terr_d   = 1'b0;
    err_id_d = err_id_q;

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = SEND;
          ptr_d   = win_idx;
          data_d  = req_bytes[win_idx];
          grant_d = win_onehot;
          send_d  = 1'b1;
        end
      end
      SEND: begin
        state_d = WAIT_DONE;
        wd_d    = '0;
      end
      WAIT_DONE: begin
        if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
        // A completion on the terminal watchdog cycle takes priority over the abort.
        if (uart_tx_done) begin
          ack_d   = grant_q;
          grant_d = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else if (wd_d == WD_MAX) begin
          terr_d   = 1'b1;
          err_id_d = 3'(ptr_q);
          grant_d  = '0;
          gap_d    = '0;
          state_d  = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
        if (gap_d == GAP_MAX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_INIT;
      wd_q     <= '0;
      gap_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      send_q   <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wd_q     <= wd_d;
      gap_q    <= gap_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      send_q   <= send_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      err_id_q <= err_id_d;
    end
  end

  assign grant        = grant_q;
  assign ack          = ack_q;
  assign uart_send    = send_q;
  assign uart_tx_data = data_q;
  assign busy         = busy_q;
  assign timeout_err  = terr_q;
  assign err_id       = err_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected frames are queued as requests
// are driven; a negedge monitor plays the UART and pops them as frames start.
module tb_uart_tx_arbiter;

  localparam int N_REQ      = 4;
  localparam int GAP_CYCLES = 16;
  localparam int TIMEOUT    = 50;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         delay;
    bit         expTimeout;
    bit         gapCheck;
  } frame_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] ack;
  logic             uart_send;
  logic [7:0]       uart_tx_data;
  logic             uart_tx_done = 1'b0;
  logic             busy;
  logic             timeout_err;
  logic [2:0]       err_id;

  int     checkCount = 0;
  int     errorCount = 0;
  int     cyc = 0;
  int     doneCnt = 0;
  int     stubCnt = -1;
  int     sendCyc = 0;
  int     endCyc = 0;
  frame_t expQ[$];
  frame_t cur;

  uart_tx_arbiter #(
    .N_REQ      (N_REQ),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .ack          (ack),
    .uart_send    (uart_send),
    .uart_tx_data (uart_tx_data),
    .uart_tx_done (uart_tx_done),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .err_id       (err_id)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %0h expected %0h at cycle %0d", tag, observed, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] reqVal);
    req = reqVal;
  endtask

  task automatic pushFrame(input int idx, input logic [7:0] data, input int delay,
                           input bit expTimeout, input bit gapCheck);
    frame_t f;
    f.idx        = idx;
    f.data       = data;
    f.delay      = delay;
    f.expTimeout = expTimeout;
    f.gapCheck   = gapCheck;
    expQ.push_back(f);
  endtask

  task automatic waitDone(input int n, input int budget);
    int target;
    target = doneCnt + n;
    for (int i = 0; i < budget && doneCnt < target; i++) tick(1);
    checkOutput("waitDone", 32'(doneCnt >= target), 1);
  endtask

  task automatic applyReset();
    reset = 1'b0;
    req   = '0;
    tick(2);
    checkOutput("rstGrant", 32'(grant), 0);
    checkOutput("rstAck", 32'(ack), 0);
    checkOutput("rstSend", 32'(uart_send), 0);
    checkOutput("rstData", 32'(uart_tx_data), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstTerr", 32'(timeout_err), 0);
    checkOutput("rstErrId", 32'(err_id), 0);
    reset = 1'b1;
    tick(2);
  endtask

  // Monitor and UART stub: pops expectations on uart_send, answers with tx_done.
  always @(negedge clock) begin
    uart_tx_done = 1'b0;
    if (!reset) begin
      stubCnt = -1;
      expQ.delete();
    end else begin
      checkOutput("grantOneHot", 32'($countones(grant) > 1), 0);
      if (stubCnt > 0) begin
        stubCnt--;
        if (stubCnt == 0) begin
          uart_tx_done = 1'b1;
          checkOutput("dataStable", 32'(uart_tx_data), 32'(cur.data));
        end
      end
      if (uart_send) begin
        checkOutput("sendExpected", 32'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          cur = expQ.pop_front();
          checkOutput("grantIdx", 32'(grant), 32'(1) << cur.idx);
          checkOutput("txData", 32'(uart_tx_data), 32'(cur.data));
          if (cur.gapCheck) checkOutput("gapSpacing", 32'(cyc - endCyc), GAP_CYCLES + 1);
          stubCnt = cur.delay;
          sendCyc = cyc;
        end
      end
      if (|ack) begin
        checkOutput("ackVec", 32'(ack), 32'(1) << cur.idx);
        checkOutput("ackNotTimeout", 32'(cur.expTimeout), 0);
        checkOutput("ackNoErr", 32'(timeout_err), 0);
        checkOutput("ackLatency", 32'(cyc - sendCyc), 32'(cur.delay + 1));
        checkOutput("ackGrantClr", 32'(grant), 0);
        stubCnt = -1;
        endCyc  = cyc;
        doneCnt++;
      end
      if (timeout_err) begin
        checkOutput("errId", 32'(err_id), 32'(cur.idx));
        checkOutput("errExpected", 32'(cur.expTimeout), 1);
        checkOutput("errNoAck", 32'(ack), 0);
        checkOutput("errLatency", 32'(cyc - sendCyc), TIMEOUT + 1);
        stubCnt = -1;
        endCyc  = cyc;
        doneCnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL globalTimeout simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    applyReset();

    // Single requester; req dropped while granted must not abort the frame.
    req_data = {8'h00, 8'h00, 8'h00, 8'hF0};
    pushFrame(0, 8'hF0, 40, 1'b0, 1'b0);
    applyStimulus(4'b0001);
    tick(1);
    checkOutput("sendLatency", 32'(uart_send), 1);
    checkOutput("sendBusy", 32'(busy), 1);
    applyStimulus(4'b0000);
    tick(1);
    checkOutput("sendOnePulse", 32'(uart_send), 0);
    waitDone(1, 200);
    tick(15);
    checkOutput("gapBusyHigh", 32'(busy), 1);
    tick(1);
    checkOutput("gapBusyLow", 32'(busy), 0);
    checkOutput("queueEmpty1", 32'(expQ.size()), 0);

    // Continuous requests from all four sources rotate 0,1,2,3,0.
    applyReset();
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    pushFrame(0, 8'h10, 20, 1'b0, 1'b0);
    pushFrame(1, 8'h21, 20, 1'b0, 1'b1);
    pushFrame(2, 8'h32, 20, 1'b0, 1'b1);
    pushFrame(3, 8'h43, 20, 1'b0, 1'b1);
    pushFrame(0, 8'h10, 20, 1'b0, 1'b1);
    applyStimulus(4'b1111);
    waitDone(5, 1000);
    applyStimulus(4'b0000);
    checkOutput("queueEmpty2", 32'(expQ.size()), 0);

    // Watchdog abort on requester 0, then requester 1 served after the gap.
    applyReset();
    req_data = {8'h00, 8'h00, 8'h22, 8'h11};
    pushFrame(0, 8'h11, -1, 1'b1, 1'b0);
    pushFrame(1, 8'h22, 20, 1'b0, 1'b1);
    applyStimulus(4'b0011);
    waitDone(2, 400);
    applyStimulus(4'b0000);
    checkOutput("queueEmpty3", 32'(expQ.size()), 0);

    // tx_done on the terminal watchdog cycle wins over the abort.
    applyReset();
    req_data = {8'h00, 8'h00, 8'h77, 8'h00};
    pushFrame(1, 8'h77, TIMEOUT, 1'b0, 1'b0);
    applyStimulus(4'b0010);
    waitDone(1, 200);
    applyStimulus(4'b0000);
    checkOutput("queueEmpty4", 32'(expQ.size()), 0);

    // Asynchronous reset in the middle of WAIT_DONE.
    applyReset();
    req_data = {8'h00, 8'h33, 8'h00, 8'h44};
    pushFrame(0, 8'h44, -1, 1'b1, 1'b0);
    applyStimulus(4'b0001);
    tick(10);
    checkOutput("midGrant", 32'(grant), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncGrant", 32'(grant), 0);
    checkOutput("asyncBusy", 32'(busy), 0);
    checkOutput("asyncSend", 32'(uart_send), 0);
    applyReset();
    pushFrame(0, 8'h44, 10, 1'b0, 1'b0);
    applyStimulus(4'b0101);
    waitDone(1, 200);
    applyStimulus(4'b0000);
    checkOutput("queueEmpty5", 32'(expQ.size()), 0);

    // Two frames from requesters 1 and 3; data change after latch is ignored.
    applyReset();
    req_data = {8'h5A, 8'h00, 8'hA5, 8'h00};
    pushFrame(1, 8'hA5, 30, 1'b0, 1'b0);
    pushFrame(3, 8'h5A, 30, 1'b0, 1'b1);
    applyStimulus(4'b1010);
    tick(3);
    req_data[15:8] = 8'hFF;
    waitDone(2, 400);
    applyStimulus(4'b0000);
    checkOutput("queueEmpty6", 32'(expQ.size()), 0);

    tick(GAP_CYCLES + 4);
    checkOutput("finalIdle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
